// File: rtl/lfsr_rand_sampler.sv
// Seeds and steps an external XNOR LFSR, rejection-samples its output into [0, range)
// and offers one value at a time on a valid/ready port, with a bounded-latency fallback.
module lfsr_rand_sampler #(
    parameter int NUM_BITS  = 8,
    parameter int MAX_TRIES = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Start,
    input  logic [NUM_BITS-1:0] i_Range,
    input  logic [NUM_BITS-1:0] i_LFSR_Data,
    output logic                o_LFSR_Enable,
    output logic                o_Seed_DV,
    output logic [NUM_BITS-1:0] o_Seed_Data,
    output logic                o_Rand_Valid,
    input  logic                i_Rand_Ready,
    output logic [NUM_BITS-1:0] o_Rand_Data,
    output logic                o_Rand_Fallback
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        DRAW = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] seed_cnt_q, seed_cnt_d;
    logic [NUM_BITS-1:0] seed_data_q, seed_data_d;
    logic [NUM_BITS-1:0] range_q, range_d;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [NUM_BITS-1:0] fb_cnt_q, fb_cnt_d;
    logic [NUM_BITS-1:0] data_q, data_d;
    logic                fallback_q, fallback_d;
    logic                valid_q, valid_d;
    logic                lfsr_en_q, lfsr_en_d;
    logic                seed_dv_q, seed_dv_d;

    // All-ones is the XNOR lock-up state, so it is swapped for zero.
    function automatic logic [NUM_BITS-1:0] safe_seed(input logic [NUM_BITS-1:0] cnt);
        return (&cnt) ? '0 : cnt;
    endfunction

    function automatic logic accept(input logic [NUM_BITS-1:0] cand,
                                    input logic [NUM_BITS-1:0] rng);
        return (rng == '0) || (cand < rng);
    endfunction

    function automatic logic [NUM_BITS-1:0] fb_wrap(input logic [NUM_BITS-1:0] cnt,
                                                    input logic [NUM_BITS-1:0] rng);
        logic [NUM_BITS:0] nxt;
        nxt = {1'b0, cnt} + {{NUM_BITS{1'b0}}, 1'b1};
        return (nxt >= {1'b0, rng}) ? '0 : nxt[NUM_BITS-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        seed_cnt_d  = seed_cnt_q + {{(NUM_BITS-1){1'b0}}, 1'b1};
        seed_data_d = seed_data_q;
        range_d     = range_q;
        tries_d     = tries_q;
        fb_cnt_d    = fb_cnt_q;
        data_d      = data_q;
        fallback_d  = fallback_q;
        valid_d     = valid_q;

        if (i_Start) begin
            seed_data_d = safe_seed(seed_cnt_q);
            valid_d     = 1'b0;
            fallback_d  = 1'b0;
            fb_cnt_d    = '0;
            state_d     = SEED;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                SEED: begin
                    range_d = i_Range;
                    tries_d = '0;
                    state_d = DRAW;
                end
                DRAW: begin
                    if (accept(i_LFSR_Data, range_q)) begin
                        data_d     = i_LFSR_Data;
                        fallback_d = 1'b0;
                        valid_d    = 1'b1;
                        state_d    = HOLD;
                    end else if (tries_q == LAST_TRY) begin
                        data_d     = fb_cnt_q;
                        fallback_d = 1'b1;
                        valid_d    = 1'b1;
                        fb_cnt_d   = fb_wrap(fb_cnt_q, range_q);
                        state_d    = HOLD;
                    end else begin
                        tries_d = tries_q + {{(TRY_W-1){1'b0}}, 1'b1};
                    end
                end
                HOLD: begin
                    if (valid_q && i_Rand_Ready) begin
                        valid_d = 1'b0;
                        range_d = i_Range;
                        tries_d = '0;
                        state_d = DRAW;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // LFSR controls are decoded from the next state so they arrive registered.
        lfsr_en_d = (state_d == SEED) || (state_d == DRAW);
        seed_dv_d = (state_d == SEED);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= IDLE;
            seed_cnt_q  <= '0;
            seed_data_q <= '0;
            range_q     <= '0;
            tries_q     <= '0;
            fb_cnt_q    <= '0;
            data_q      <= '0;
            fallback_q  <= 1'b0;
            valid_q     <= 1'b0;
            lfsr_en_q   <= 1'b0;
            seed_dv_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_cnt_q  <= seed_cnt_d;
            seed_data_q <= seed_data_d;
            range_q     <= range_d;
            tries_q     <= tries_d;
            fb_cnt_q    <= fb_cnt_d;
            data_q      <= data_d;
            fallback_q  <= fallback_d;
            valid_q     <= valid_d;
            lfsr_en_q   <= lfsr_en_d;
            seed_dv_q   <= seed_dv_d;
        end
    end

    assign o_LFSR_Enable   = lfsr_en_q;
    assign o_Seed_DV       = seed_dv_q;
    assign o_Seed_Data     = seed_data_q;
    assign o_Rand_Valid    = valid_q;
    assign o_Rand_Data     = data_q;
    assign o_Rand_Fallback = fallback_q;

endmodule

// File: tb/tb_lfsr_rand_sampler.sv
// Bench for lfsr_rand_sampler: drives a behavioural 8-bit XNOR LFSR and checks
// every delivered value against a sequence-level rejection-sampling model.
module tb_lfsr_rand_sampler;

    localparam int NB = 8;
    localparam int MT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NB-1:0] range;
    logic [NB-1:0] lfsr_q;
    logic          lfsr_en;
    logic          seed_dv;
    logic [NB-1:0] seed_data;
    logic          valid;
    logic          ready;
    logic [NB-1:0] data;
    logic          fallback;

    always #5 clk = ~clk;

    lfsr_rand_sampler #(.NUM_BITS(NB), .MAX_TRIES(MT)) dut (
        .i_Clk          (clk),
        .i_Rst_n        (rst_n),
        .i_Start        (start),
        .i_Range        (range),
        .i_LFSR_Data    (lfsr_q),
        .o_LFSR_Enable  (lfsr_en),
        .o_Seed_DV      (seed_dv),
        .o_Seed_Data    (seed_data),
        .o_Rand_Valid   (valid),
        .i_Rand_Ready   (ready),
        .o_Rand_Data    (data),
        .o_Rand_Fallback(fallback)
    );

    // XNOR LFSR, taps 8,6,5,4; all-ones is its lock-up state.
    function automatic logic [NB-1:0] lfsr_next(input logic [NB-1:0] x);
        return {x[6:0], ~(x[7] ^ x[5] ^ x[4] ^ x[3])};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lfsr_q <= '0;
        else if (seed_dv) lfsr_q <= seed_data;
        else if (lfsr_en) lfsr_q <= lfsr_next(lfsr_q);
    end

    // Cycle count since reset release: what the free-running seed counter should hold.
    logic [NB-1:0] tb_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= '0;
        else        tb_cnt <= tb_cnt + 8'd1;
    end

    int vectors = 0;
    int miscompares = 0;
    int handshakes = 0;

    logic [NB-1:0] m_lfsr, m_fb, m_range;
    logic          s_valid, s_en, s_dv, s_fb;
    logic [NB-1:0] s_data, s_seed;
    logic          prev_hold;
    logic [NB-1:0] prev_data;
    logic          prev_fb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One draw: walk the LFSR sequence up to MT candidates, else emit the wrapping counter.
    task automatic model_draw(output logic [NB-1:0] v, output logic f);
        logic [NB-1:0] cand;
        for (int t = 0; t < MT; t++) begin
            cand   = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            if (m_range == 0 || cand < m_range) begin
                v = cand;
                f = 1'b0;
                return;
            end
        end
        v    = m_fb;
        f    = 1'b1;
        m_fb = (int'(m_fb) + 1 >= int'(m_range)) ? 8'd0 : m_fb + 8'd1;
    endtask

    task automatic sample();
        s_valid = valid;
        s_en    = lfsr_en;
        s_dv    = seed_dv;
        s_fb    = fallback;
        s_data  = data;
        s_seed  = seed_data;
    endtask

    task automatic step(input logic rdy);
        logic [NB-1:0] ev;
        logic          ef;
        @(negedge clk);
        ready = rdy;
        #1;
        sample();
        if (s_valid) begin
            check("hold_lfsr_en", s_en, 0);
            if (prev_hold) begin
                check("hold_data", s_data, prev_data);
                check("hold_fb", s_fb, prev_fb);
            end
        end
        if (s_valid && rdy) begin
            model_draw(ev, ef);
            check("data", s_data, ev);
            check("fallback", s_fb, ef);
            if (m_range != 0) check("in_range", s_data < m_range, 1);
            handshakes++;
        end
        prev_hold = s_valid && !rdy;
        prev_data = s_data;
        prev_fb   = s_fb;
    endtask

    task automatic do_start(input logic [NB-1:0] target, input logic [NB-1:0] rng);
        int n = 0;
        range = rng;
        @(negedge clk);
        while (tb_cnt != target && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("start_wait", tb_cnt == target, 1);
        start     = 1'b1;
        m_lfsr    = (target == 8'hFF) ? 8'h00 : target;
        m_fb      = '0;
        m_range   = rng;
        prev_hold = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        sample();
        check("seed_dv", s_dv, 1);
        check("seed_data", s_seed, m_lfsr);
        check("seed_lfsr_en", s_en, 1);
        check("seed_valid", s_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [NB-1:0] tgt;
        rst_n = 1'b0; start = 1'b0; range = '0; ready = 1'b0; prev_hold = 1'b0;
        prev_data = '0; prev_fb = 1'b0;
        #23;
        sample();
        check("rst_valid", s_valid, 0);
        check("rst_en", s_en, 0);
        check("rst_seed_dv", s_dv, 0);
        check("rst_seed_data", s_seed, 0);
        check("rst_data", s_data, 0);
        check("rst_fb", s_fb, 0);
        rst_n = 1'b1;

        // Full range, seed 0x2A, always ready: first value at E2, then every other cycle.
        ready = 1'b1;
        do_start(8'h2A, 8'd0);
        step(1'b1); check("t1_lat_e1", s_valid, 0); check("t1_dv_off", s_dv, 0);
        step(1'b1); check("t1_lat_e2", s_valid, 1); check("t1_first", s_data, 8'h2A);
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            check("t1_rate", s_valid, i % 2);
        end

        // Seed counter at all-ones must load zero and never lock the LFSR.
        do_start(8'hFF, 8'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            check("t2_no_lock", lfsr_q == 8'hFF, 0);
        end

        // Range 1 from seed 0x05: four rejects then fallback zero at E5.
        do_start(8'h05, 8'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            check("t3_no_valid", s_valid, 0);
        end
        step(1'b1);
        check("t3_valid_e5", s_valid, 1);
        check("t3_fb", s_fb, 1);
        check("t3_data", s_data, 0);
        handshakes = 0;
        cyc = 0;
        while (handshakes < 2 && cyc < 50) begin step(1'b1); cyc++; end
        check("t3_second", handshakes, 2);

        // Range 10, random ready, 1000 values.
        do_start(8'h9C, 8'd10);
        handshakes = 0;
        cyc = 0;
        while (handshakes < 1000 && cyc < 20000) begin
            step(1'($urandom_range(0, 1)));
            cyc++;
        end
        check("t4_count", handshakes, 1000);

        // Pending value discarded by Start.
        do_start(8'h31, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b1);
        cyc = 0;
        do begin step(1'b0); cyc++; end while (!s_valid && cyc < 10);
        check("t5_pending", s_valid, 1);
        step(1'b0);
        step(1'b0);
        tgt = tb_cnt + 8'd2;
        do_start(tgt, 8'd0);
        step(1'b1); check("t5_e1", s_valid, 0);
        step(1'b1); check("t5_e2", s_valid, 1);
        for (int i = 0; i < 6; i++) step(1'b1);

        // Asynchronous reset mid-draw.
        do_start(8'h77, 8'd1);
        step(1'b1);
        step(1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sample();
        check("t6_valid", s_valid, 0);
        check("t6_en", s_en, 0);
        check("t6_dv", s_dv, 0);
        check("t6_seed", s_seed, 0);
        check("t6_data", s_data, 0);
        check("t6_fb", s_fb, 0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            check("t6_idle_valid", s_valid, 0);
            check("t6_idle_en", s_en, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
